// File: rtl/ecc_83_pkg.sv
// ecc_83_pkg: shared constants and types for the 83-bit SECDED write encoder.
//   DATA_WIDTH / PARITY_WIDTH : codeword geometry (83 data + 7 Hamming + 1 overall)
//   inj_mode_e                : one-shot corruption selector encodings
//   inj_state_e               : injection FSM states
//   data_pos()                : data bit index -> Hamming codeword position
package ecc_83_pkg;

  localparam int unsigned DATA_WIDTH   = 83;
  localparam int unsigned PARITY_WIDTH = 8;
  localparam int unsigned HAM_WIDTH    = 7;
  localparam int unsigned POS_MAX      = DATA_WIDTH + HAM_WIDTH;

  typedef enum logic [1:0] {
    INJ_NONE = 2'b00,
    INJ_D0   = 2'b01,
    INJ_D01  = 2'b10,
    INJ_P7   = 2'b11
  } inj_mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ARMED = 1'b1
  } inj_state_e;

  typedef logic [HAM_WIDTH-1:0] pos_t;

  // Data bits occupy the non-power-of-two positions 3..90 in ascending order.
  function automatic pos_t data_pos(input int unsigned idx);
    int unsigned cnt;
    pos_t        pos;
    cnt = 0;
    pos = '0;
    for (int unsigned p = 1; p <= POS_MAX; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == idx) pos = pos_t'(p);
        cnt++;
      end
    end
    return pos;
  endfunction

endpackage

// File: rtl/ecc_83_enc.sv
// ecc_83_enc: combinational SECDED parity generator.
//   data   : payload
//   parity : {overall, hamming[6:0]}; hamming[i] = XOR of data at positions with bit i set
module ecc_83_enc #(
  parameter int unsigned DATA_WIDTH   = ecc_83_pkg::DATA_WIDTH,
  parameter int unsigned PARITY_WIDTH = ecc_83_pkg::PARITY_WIDTH
) (
  input  logic [DATA_WIDTH-1:0]   data,
  output logic [PARITY_WIDTH-1:0] parity
);

  import ecc_83_pkg::pos_t;
  import ecc_83_pkg::data_pos;

  pos_t ham;

  // XOR-ing each set bit's position builds every Hamming bit at once.
  always_comb begin
    ham = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      if (data[i]) ham = ham ^ data_pos(i);
    end
  end

  // Overall parity covers the data and the seven Hamming bits.
  assign parity = PARITY_WIDTH'({(^data) ^ (^ham), ham});

endmodule

// File: rtl/ecc_83_wr_enc.sv
// ecc_83_wr_enc: registered SECDED write-path encoder with a redundant-encoder
// checker, one-shot fault injection and fault statistics.
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid/in_ready        : input handshake, data_in payload, bypass zeroes parity
//   ecc_fault_detc_en        : enable encoder-0 vs encoder-1 compare
//   tst_enc_flip             : invert parity bit 0 of encoder 1 (checker self-test)
//   inj_req/inj_mode/inj_busy: arm a one-shot corruption of the next accepted word
//   out_valid/out_ready      : output handshake; data_out, parity_out, ecc_fault
//   fault_sticky/fault_cnt   : flagged-word statistics, cleared by fault_clr
module ecc_83_wr_enc #(
  parameter int unsigned DATA_WIDTH   = ecc_83_pkg::DATA_WIDTH,
  parameter int unsigned PARITY_WIDTH = ecc_83_pkg::PARITY_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    bypass,
  input  logic                    ecc_fault_detc_en,
  input  logic                    tst_enc_flip,
  input  logic                    inj_req,
  input  logic [1:0]              inj_mode,
  output logic                    inj_busy,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic [PARITY_WIDTH-1:0] parity_out,
  output logic                    ecc_fault,
  output logic                    fault_sticky,
  input  logic                    fault_clr,
  output logic [7:0]              fault_cnt
);

  import ecc_83_pkg::inj_mode_e;
  import ecc_83_pkg::inj_state_e;
  import ecc_83_pkg::INJ_NONE;
  import ecc_83_pkg::INJ_D0;
  import ecc_83_pkg::INJ_D01;
  import ecc_83_pkg::INJ_P7;
  import ecc_83_pkg::ST_IDLE;
  import ecc_83_pkg::ST_ARMED;

  logic                    accept;
  logic [PARITY_WIDTH-1:0] par0;
  logic [PARITY_WIDTH-1:0] par1;
  logic [PARITY_WIDTH-1:0] par1_chk;
  logic                    mismatch;
  logic                    fault_c;
  logic [DATA_WIDTH-1:0]   data_c;
  logic [PARITY_WIDTH-1:0] par_c;
  inj_state_e              state_q, state_d;
  inj_mode_e               mode_q, mode_d;

  // Handshake: the single output stage frees up when it is empty or draining.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // Primary and redundant encoders; the codeword always comes from encoder 0.
  ecc_83_enc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_enc0 (
    .data  (data_in),
    .parity(par0)
  );

  ecc_83_enc #(
    .DATA_WIDTH  (DATA_WIDTH),
    .PARITY_WIDTH(PARITY_WIDTH)
  ) u_enc1 (
    .data  (data_in),
    .parity(par1)
  );

  // Self-test perturbs only the redundant copy so the compare must trip.
  assign par1_chk = par1 ^ PARITY_WIDTH'(tst_enc_flip);
  assign mismatch = (par0 != par1_chk);
  assign fault_c  = mismatch & ecc_fault_detc_en & ~bypass;

  // Codeword build; corruption is applied after the compare so it is not flagged.
  always_comb begin
    data_c = data_in;
    par_c  = bypass ? '0 : par0;
    if (state_q == ST_ARMED) begin
      case (mode_q)
        INJ_D0:  data_c[0]              = ~data_c[0];
        INJ_D01: data_c[1:0]            = ~data_c[1:0];
        INJ_P7:  par_c[PARITY_WIDTH-1]  = ~par_c[PARITY_WIDTH-1];
        default: ;
      endcase
    end
  end

  // Injection FSM next-state; requests while armed are ignored.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      ST_IDLE: begin
        if (inj_req && (inj_mode_e'(inj_mode) != INJ_NONE)) begin
          state_d = ST_ARMED;
          mode_d  = inj_mode_e'(inj_mode);
        end
      end
      ST_ARMED: begin
        if (accept) begin
          state_d = ST_IDLE;
          mode_d  = INJ_NONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        mode_d  = INJ_NONE;
      end
    endcase
  end

  // Injection FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= INJ_NONE;
      inj_busy <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      inj_busy <= (state_d == ST_ARMED);
    end
  end

  // Output register stage; payload holds while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      data_out   <= '0;
      parity_out <= '0;
      ecc_fault  <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      data_out   <= data_c;
      parity_out <= par_c;
      ecc_fault  <= fault_c;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Fault statistics; a clear wins over a simultaneous flagged load.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else if (fault_clr) begin
      fault_sticky <= 1'b0;
      fault_cnt    <= '0;
    end else if (accept && fault_c) begin
      fault_sticky <= 1'b1;
      if (fault_cnt != 8'hFF) fault_cnt <= fault_cnt + 8'd1;
    end
  end

endmodule

// File: doc/ecc_83_wr_enc.md
ECC_83_WR_ENC -- requirements
Module: ecc_83_wr_enc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 83, payload width.
REQ-002 SHALL have parameter PARITY_WIDTH, default 8, SECDED check width (7 Hamming + 1 overall).
REQ-003 SHALL have port clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  write word offered.
REQ-006 SHALL have port in_ready  output  1  word accepted when in_valid & in_ready.
REQ-007 SHALL have port data_in  input  DATA_WIDTH  payload.
REQ-008 SHALL have port bypass  input  1  force parity to zero, sampled with the word.
REQ-009 SHALL have port ecc_fault_detc_en  input  1  enable redundant-encoder compare.
REQ-010 SHALL have port tst_enc_flip  input  1  invert parity bit 0 of redundant encoder 1 only (checker self-test).
REQ-011 SHALL have port inj_req  input  1  pulse; arm one-shot codeword corruption.
REQ-012 SHALL have port inj_mode  input  2  00 none, 01 flip data bit 0, 10 flip data bits 0 and 1, 11 flip parity bit 7; sampled with inj_req.
REQ-013 SHALL have port inj_busy  output  1  corruption armed, not yet applied.
REQ-014 SHALL have port out_valid  output  1  codeword available.
REQ-015 SHALL have port out_ready  input  1  downstream (FIFO memory) takes codeword.
REQ-016 SHALL have port data_out  output  DATA_WIDTH  registered payload.
REQ-017 SHALL have port parity_out  output  PARITY_WIDTH  registered parity.
REQ-018 SHALL have port ecc_fault  output  1  per-word flag, travels with codeword.
REQ-019 SHALL have port fault_sticky  output  1  set on any flagged word, cleared by fault_clr.
REQ-020 SHALL have port fault_clr  input  1  clear fault_sticky and fault_cnt.
REQ-021 SHALL have port fault_cnt  output  8  saturating count of flagged words.

Function
REQ-022 Encoding SHALL be bit-compatible with ecc_83_cal: data bits placed in order at non-power-of-two positions 3..90; parity[i] (i=0..6) = XOR of positions with bit i set; parity[7] = XOR of all data and parity[6:0].
REQ-023 bypass=1 SHALL give parity_out = 0 and ecc_fault = 0 for that word.
REQ-024 Output SHALL be a single register stage: latency exactly 1 cycle from acceptance to out_valid.
REQ-025 in_ready SHALL equal ~out_valid | out_ready (full throughput, no combinational path from in_valid).
REQ-026 out_valid & ~out_ready SHALL hold data_out, parity_out, ecc_fault stable.
REQ-027 Compare SHALL be parity0 != parity1; ecc_fault = mismatch & ecc_fault_detc_en; codeword always from encoder 0.
REQ-028 Injection FSM SHALL have states IDLE and ARMED: IDLE->ARMED on inj_req with inj_mode != 00; ARMED->IDLE on the next accepted word, which receives the corruption after the compare.
REQ-029 A word accepted in the same cycle as inj_req SHALL NOT be corrupted; inj_req in ARMED SHALL be ignored.
REQ-030 inj_busy SHALL be 1 exactly in ARMED.
REQ-031 fault_sticky and fault_cnt SHALL update when a word with ecc_fault=1 is loaded into the output register; fault_cnt saturates at 255.
REQ-032 fault_clr coinciding with a flagged load SHALL give priority to the clear (result 0).

Reset
REQ-033 rst SHALL give out_valid=0, data_out=0, parity_out=0, ecc_fault=0, fault_sticky=0, fault_cnt=0, FSM IDLE, inj_busy=0.
REQ-034 rst mid-transfer SHALL discard the held word and any armed injection; in_ready=1 the cycle after reset deasserts.

Structure
REQ-035 Package ecc_83_pkg SHALL hold DATA_WIDTH, PARITY_WIDTH, inj_mode encodings, FSM state type and the data-to-position table.
REQ-036 Sub-module ecc_83_enc (combinational data -> parity) SHALL be instantiated twice.

Verification
REQ-037 data_in=0, bypass=0 -> next cycle out_valid=1, parity_out=8'h00, ecc_fault=0.
REQ-038 data_in=1 (bit 0 only) -> parity_out=8'h83.
REQ-039 tst_enc_flip=1, ecc_fault_detc_en=1, 3 words -> ecc_fault=1 each, fault_cnt=3, fault_sticky=1; same with detc_en=0 -> no flags.
REQ-040 inj_req with inj_mode=10, then data_in=1 -> data_out=83'h2 with parity_out=8'h83, inj_busy 1->0; following word uncorrupted.
REQ-041 out_ready=0 for 4 cycles with in_valid=1 -> one word held stable, in_ready=0, no loss or duplication after release.
REQ-042 300 flagged words -> fault_cnt=255; fault_clr with a flagged load -> fault_cnt=0, fault_sticky=0.
